// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: in-order request controller for a single-port synchronous RAM,
// returning every read/write response through a small credit-guarded FIFO.
module sp_ram_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic                  data_wr,
    output logic [DATA_W-1:0]     rdata,
    input  logic                  rsp_ready,
    output logic                  ram_ce,
    output logic                  ram_oce,
    output logic                  ram_reset,
    output logic                  ram_wre,
    output logic [ADDR_W-1:0]     ram_ad,
    output logic [DATA_W/8-1:0]   ram_byte_en,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
);
    localparam int CW = $clog2(RSP_DEPTH + 2);
    localparam int PW = $clog2(RSP_DEPTH);

    logic [CW-1:0]     count, occ;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              inflight, infl_wr, issue, pop;
    logic [RSP_DEPTH-1:0] fifo_wr;
    logic [DATA_W-1:0] fifo_data [RSP_DEPTH];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // A request needs a free FIFO slot reserved for it, counting the in-flight one
    assign pop         = data_ok & rsp_ready;
    assign occ         = count + CW'(inflight) - CW'(pop);
    assign addr_ok     = resetn & (occ < CW'(RSP_DEPTH));
    assign issue       = req & addr_ok;
    assign ram_ce      = issue;
    assign ram_wre     = issue & wr;
    assign ram_ad      = addr;
    assign ram_din     = wdata;
    assign ram_byte_en = wr ? wstrb : '1;
    assign ram_oce     = 1'b1;
    assign ram_reset   = 1'b0;
    assign data_ok     = count != '0;
    assign data_wr     = data_ok & fifo_wr[rd_ptr];
    assign rdata       = data_ok ? fifo_data[rd_ptr] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            infl_wr  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) infl_wr <= wr;
            if (inflight) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(inflight) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_wr[wr_ptr]   <= infl_wr;
            fifo_data[wr_ptr] <= infl_wr ? '0 : ram_dout;
        end
    end
endmodule

// File: tb/tb_sp_ram_ctrl.sv
// tb_sp_ram_ctrl: scoreboard bench with a RAM macro model and a word-level
// reference memory; a monitor predicts handshake timing and response contents.
module tb_sp_ram_ctrl;
    localparam int RSP_DEPTH = 2;

    logic        clk = 0, resetn = 0;
    logic        req = 0, wr = 0, rsp_ready = 0;
    logic [7:0]  addr = 0;
    logic [3:0]  wstrb = 0;
    logic [31:0] wdata = 0;
    logic        addr_ok, data_ok, data_wr, ram_ce, ram_oce, ram_reset, ram_wre;
    logic [31:0] rdata, ram_din, ram_dout;
    logic [7:0]  ram_ad;
    logic [3:0]  ram_byte_en;

    sp_ram_ctrl #(.ADDR_W(8), .DATA_W(32), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb),
        .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .data_wr(data_wr),
        .rdata(rdata), .rsp_ready(rsp_ready), .ram_ce(ram_ce), .ram_oce(ram_oce),
        .ram_reset(ram_reset), .ram_wre(ram_wre), .ram_ad(ram_ad),
        .ram_byte_en(ram_byte_en), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM macro: registered read data appears the cycle after the access edge
    logic [31:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byte_en[b]) ram_mem[ram_ad][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= ram_mem[ram_ad];
            end
        end
    end

    typedef struct {
        logic        w;
        logic [31:0] d;
        int          rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [256];
    int          checks = 0, errors = 0, cyc = 0, rsp_mode = 0;
    logic        acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 2ns before each rising edge, once inputs have settled
    initial begin
        logic        pop, exp_dok;
        logic [31:0] merged;
        forever begin
            @(negedge clk);
            #3;
            if (!resetn) begin
                acc = 0;
            end else begin
                cyc++;
                pop = data_ok && rsp_ready;
                chk("occupancy_bound", exp_q.size() <= RSP_DEPTH, 1'b1);
                chk("addr_ok", addr_ok, (exp_q.size() - int'(pop)) < RSP_DEPTH);
                exp_dok = exp_q.size() > 0 && exp_q[0].rdy <= cyc;
                chk("data_ok", data_ok, exp_dok);
                if (data_ok && exp_q.size() > 0) begin
                    chk("data_wr", data_wr, exp_q[0].w);
                    chk("rdata", rdata, exp_q[0].d);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
                acc = req && addr_ok;
                if (acc) begin
                    chk("ram_ce", ram_ce, 1'b1);
                    chk("ram_wre", ram_wre, wr);
                    chk("ram_ad", ram_ad, addr);
                    chk("ram_byte_en", ram_byte_en, wr ? wstrb : 4'hF);
                    if (wr) begin
                        chk("ram_din", ram_din, wdata);
                        merged = ref_mem[addr];
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
                        ref_mem[addr] = merged;
                        exp_q.push_back('{1'b1, 32'h0, cyc + 2});
                    end else begin
                        exp_q.push_back('{1'b0, ref_mem[addr], cyc + 2});
                    end
                end else begin
                    chk("ram_ce_idle", ram_ce, 1'b0);
                    chk("ram_wre_idle", ram_wre, 1'b0);
                end
            end
        end
    end

    // Consumer: 0 = stall, 1 = always ready, 2 = random, 3 = driven by main thread
    initial forever begin
        @(negedge clk);
        if (rsp_mode == 0) rsp_ready = 0;
        else if (rsp_mode == 1) rsp_ready = 1;
        else if (rsp_mode == 2) rsp_ready = $urandom_range(0, 3) != 0;
    end

    task automatic do_req(input logic w, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req = 1; wr = w; addr = a; wstrb = s; wdata = d;
        forever begin
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        rsp_mode = 1;
        idle(1);
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        #2;
        chk("rst_data_ok", data_ok, 1'b0);
        chk("rst_addr_ok", addr_ok, 1'b0);
        chk("rst_data_wr", data_wr, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ram_ce", ram_ce, 1'b0);
        chk("rst_ram_wre", ram_wre, 1'b0);
        chk("ram_oce", ram_oce, 1'b1);
        chk("ram_reset", ram_reset, 1'b0);
        #20 resetn = 1;
        rsp_mode = 1;

        // Single write then read
        do_req(1, 8'h05, 4'hF, 32'hDEADBEEF);
        idle(4);
        do_req(0, 8'h05, 4'h0, 32'h0);
        drain();

        // Partial strobe
        do_req(1, 8'h10, 4'hF, 32'h11223344);
        do_req(1, 8'h10, 4'b0101, 32'hAABBCCDD);
        do_req(0, 8'h10, 4'h0, 32'h0);
        drain();
        chk("partial_ref", ref_mem[8'h10], 32'h11BB33DD);

        // Streaming reads
        for (int a = 0; a < 8; a++) do_req(1, 8'(a), 4'hF, 32'(a * 3));
        drain();
        for (int a = 0; a < 8; a++) begin
            do_req(0, 8'(a), 4'h0, 32'h0);
            if (a == 0) first = cyc;
        end
        chk("stream_back_to_back", cyc - first, 7);
        drain();

        // Backpressure
        for (int a = 'h20; a <= 'h22; a++) do_req(1, 8'(a), 4'hF, $urandom);
        for (int a = 'h40; a <= 'h41; a++) do_req(1, 8'(a), 4'hF, $urandom);
        drain();
        rsp_mode = 3;
        rsp_ready = 0;
        do_req(0, 8'h20, 4'h0, 32'h0);
        do_req(0, 8'h21, 4'h0, 32'h0);
        @(negedge clk);
        addr = 8'h22;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_blocked", acc, 1'b0);
        end
        @(negedge clk);
        rsp_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_third_accept", acc, 1'b1);
        @(negedge clk);
        rsp_ready = 0;
        req = 0;
        repeat (2) @(negedge clk);
        drain();

        // Reset mid-operation
        rsp_mode = 0;
        do_req(0, 8'h40, 4'h0, 32'h0);
        do_req(0, 8'h41, 4'h0, 32'h0);
        @(negedge clk);
        #2 resetn = 0;
        #1;
        chk("midrst_data_ok", data_ok, 1'b0);
        chk("midrst_addr_ok", addr_ok, 1'b0);
        chk("midrst_ram_ce", ram_ce, 1'b0);
        exp_q.delete();
        req = 0;
        repeat (2) @(negedge clk);
        #2 resetn = 1;
        rsp_mode = 1;
        idle(5);
        do_req(0, 8'h41, 4'h0, 32'h0);
        drain();

        // Write immediately followed by a read of the same word
        do_req(1, 8'h30, 4'hF, 32'h12345678);
        do_req(0, 8'h30, 4'h0, 32'h0);
        drain();
        chk("hazard_ref", ref_mem[8'h30], 32'h12345678);

        // Randomized traffic over a small address window
        for (int a = 0; a < 16; a++) do_req(1, 8'(a), 4'hF, $urandom);
        rsp_mode = 2;
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 2));
        end
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
